regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback.
- Uses round-robin arbitration and valid/ready handshakes, and registers the granted write into the register-file write signals.
- Suppresses writes to x0.
- Provides read-side bypass so that register-file reads in the same cycle as a write see the new value.

---
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter_if : writeback bus between requesters, register file and
// the writeback arbiter.                                   Revision: 1.0
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              wb_stall;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rf_rd_data1;
  logic [DATA_W-1:0] rf_rd_data2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [CNT_W-1:0]  contention_cnt;

  modport slave (
    input  wb_stall,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
    output req0_ready, req1_ready,
    output rg_wrt_en, rg_wrt_addr, rg_wrt_data,
    output rd_data1, rd_data2, contention_cnt
  );

  modport master (
    output wb_stall,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
    input  req0_ready, req1_ready,
    input  rg_wrt_en, rg_wrt_addr, rg_wrt_data,
    input  rd_data1, rd_data2, contention_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : round-robin arbiter sharing the register-file write port
// between ALU and load writeback, with x0 suppression and read bypass.
//                                                          Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [CNT_W:0] C_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic              last_grant_q;
  logic              wrt_en_q;
  logic [ADDR_W-1:0] wrt_addr_q;
  logic [DATA_W-1:0] wrt_data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              grant0_w;
  logic              grant1_w;
  logic              xfer_w;
  logic [ADDR_W-1:0] sel_addr_w;
  logic [DATA_W-1:0] sel_data_w;
  logic [1:0]        inc_w;
  logic [CNT_W:0]    cnt_sum_w;
  logic [CNT_W-1:0]  cnt_d;
  logic              wrt_en_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0_w   = 1'b0;
    grant1_w   = 1'b0;
    if (!bus.wb_stall) begin
      grant0_w = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1_w = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
    xfer_w     = grant0_w || grant1_w;
    sel_addr_w = grant1_w ? bus.req1_addr : bus.req0_addr;
    sel_data_w = grant1_w ? bus.req1_data : bus.req0_data;
    wrt_en_d   = xfer_w && (sel_addr_w != '0);
  end

  always_comb begin
    inc_w     = {1'b0, bus.req0_valid && !grant0_w} + {1'b0, bus.req1_valid && !grant1_w};
    cnt_sum_w = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc_w};
    cnt_d     = (cnt_sum_w > C_CNT_MAX) ? C_CNT_MAX[CNT_W-1:0] : cnt_sum_w[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      wrt_en_q     <= 1'b0;
      wrt_addr_q   <= '0;
      wrt_data_q   <= '0;
      cnt_q        <= '0;
    end else begin
      wrt_en_q <= wrt_en_d;
      cnt_q    <= cnt_d;
      if (xfer_w) begin
        last_grant_q <= grant1_w;
        wrt_addr_q   <= sel_addr_w;
        wrt_data_q   <= sel_data_w;
      end
    end
  end

  assign bus.req0_ready     = grant0_w;
  assign bus.req1_ready     = grant1_w;
  assign bus.rg_wrt_en      = wrt_en_q;
  assign bus.rg_wrt_addr    = wrt_addr_q;
  assign bus.rg_wrt_data    = wrt_data_q;
  assign bus.contention_cnt = cnt_q;

  // x0 always reads through; wrt_en_q is never set for x0 anyway.
  always_comb begin
    bus.rd_data1 = bus.rf_rd_data1;
    bus.rd_data2 = bus.rf_rd_data2;
    if (wrt_en_q && (bus.rd_addr1 == wrt_addr_q) && (bus.rd_addr1 != '0))
      bus.rd_data1 = wrt_data_q;
    if (wrt_en_q && (bus.rd_addr2 == wrt_addr_q) && (bus.rd_addr2 != '0))
      bus.rd_data2 = wrt_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter : directed bench for regfile_wb_arbiter.
//                                                          Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) bus ();

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.wb_stall   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
    bus.rd_addr1    = '0;
    bus.rd_addr2    = '0;
    bus.rf_rd_data1 = '0;
    bus.rf_rd_data2 = '0;
    tick();
    tick();
    check("rst_en",   {31'd0, bus.rg_wrt_en}, 32'd0);
    check("rst_addr", {27'd0, bus.rg_wrt_addr}, 32'd0);
    check("rst_data", bus.rg_wrt_data, 32'd0);
    check("rst_cnt",  {16'd0, bus.contention_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // req0 alone
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
    #1;
    check("s1_r0rdy", {31'd0, bus.req0_ready}, 32'd1);
    check("s1_r1rdy", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle();
    check("s1_en",   {31'd0, bus.rg_wrt_en}, 32'd1);
    check("s1_addr", {27'd0, bus.rg_wrt_addr}, 32'd5);
    check("s1_data", bus.rg_wrt_data, 32'hDEADBEEF);
    tick();

    // Both valid; req0 won last, so req1 goes first: 1,0,1,0
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s2_r0rdy", {31'd0, bus.req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("s2_r1rdy", {31'd0, bus.req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      check("s2_addr", {27'd0, bus.rg_wrt_addr}, (i % 2 == 0) ? 32'd2 : 32'd1);
      check("s2_data", bus.rg_wrt_data, (i % 2 == 0) ? 32'h22 : 32'h11);
      check("s2_en",   {31'd0, bus.rg_wrt_en}, 32'd1);
    end
    idle();
    check("s2_cnt", {16'd0, bus.contention_cnt}, 32'd4);

    // Write to x0: accepted but suppressed
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h1234;
    #1;
    check("s3_r1rdy", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    idle();
    bus.rd_addr1 = 5'd0; bus.rf_rd_data1 = 32'hAAAA5555;
    #1;
    check("s3_en",  {31'd0, bus.rg_wrt_en}, 32'd0);
    check("s3_rd1", bus.rd_data1, 32'hAAAA5555);
    tick();

    // Stall with both valid for 3 cycles
    bus.wb_stall = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_r0rdy", {31'd0, bus.req0_ready}, 32'd0);
      check("s4_r1rdy", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      check("s4_en", {31'd0, bus.rg_wrt_en}, 32'd0);
    end
    check("s4_cnt", {16'd0, bus.contention_cnt}, 32'd10);
    bus.wb_stall = 1'b0;
    #1;
    check("s4_post_r0", {31'd0, bus.req0_ready}, 32'd1);
    check("s4_post_r1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle();
    check("s4_post_addr", {27'd0, bus.rg_wrt_addr}, 32'd1);
    check("s4_post_cnt",  {16'd0, bus.contention_cnt}, 32'd11);

    // Bypass
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'hCAFE0001;
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd8;
    bus.rf_rd_data1 = 32'h0; bus.rf_rd_data2 = 32'h5555AAAA;
    tick();
    idle();
    #1;
    check("s5_en",  {31'd0, bus.rg_wrt_en}, 32'd1);
    check("s5_rd1", bus.rd_data1, 32'hCAFE0001);
    check("s5_rd2", bus.rd_data2, 32'h5555AAAA);
    tick();
    check("s5_rd1_after", bus.rd_data1, 32'h0);

    // Saturation: bring count to even, then stall both to the top
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
    #1;
    check("s6_r1rdy", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    check("s6_cnt", {16'd0, bus.contention_cnt}, 32'd12);
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 32761; i++) tick();
    check("s6_cnt_m1", {16'd0, bus.contention_cnt}, 32'd65534);
    tick();
    check("s6_cnt_sat", {16'd0, bus.contention_cnt}, 32'd65535);
    tick();
    check("s6_cnt_hold", {16'd0, bus.contention_cnt}, 32'd65535);
    idle();
    tick();

    // Reset mid-flight drops the write and restores req0 preference
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
    tick();
    idle();
    check("s7_en_pre", {31'd0, bus.rg_wrt_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("s7_en_rst",  {31'd0, bus.rg_wrt_en}, 32'd0);
    check("s7_cnt_rst", {16'd0, bus.contention_cnt}, 32'd0);
    tick();
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h33;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h44;
    #1;
    check("s7_r0rdy", {31'd0, bus.req0_ready}, 32'd1);
    check("s7_r1rdy", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle();
    check("s7_addr", {27'd0, bus.rg_wrt_addr}, 32'd3);
    check("s7_data", bus.rg_wrt_data, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
